binary2unary_array: RTL and testbench

Multi-channel, mode-selectable binary-to-unary temporal encoder. Each gamma cycle, it converts NUM_CH binary values into unary spike trains, one per channel, all channels aligned to a common gamma cycle. The encoding is rising-edge, falling-edge or fixed-width pulse, chosen at run time. It sits at the front of the temporal datapath and feeds unary lines to downstream column logic. It supersedes the single-channel, compile-time-mode binary2unary encoder.

---
 rtl/b2u_pkg.sv | 16 +
 rtl/binary2unary_lane.sv | 53 +++++
 rtl/binary2unary_array.sv | 91 +++++++++
 tb/tb_binary2unary_array.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/b2u_pkg.sv
// Shared types for the multi-channel binary-to-unary temporal encoder.
package b2u_pkg;

    typedef enum logic [1:0] {
        B2U_RISING  = 2'b00,
        B2U_FALLING = 2'b01,
        B2U_PULSE   = 2'b10,
        B2U_RSVD    = 2'b11
    } b2u_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } b2u_state_e;

endpackage

// File: rtl/binary2unary_lane.sv
// One encoder channel: holds its latched value and registers the unary bit
// for the tick that follows the current one.
module binary2unary_lane
    import b2u_pkg::*;
#(
    parameter int INPUT_WIDTH = 4,
    parameter int PULSE_WIDTH = 8
) (
    input  logic                   aclk,
    input  logic                   grst,
    input  logic                   load,
    input  logic [INPUT_WIDTH-1:0] value_in,
    input  b2u_mode_e              mode,
    input  logic [INPUT_WIDTH-1:0] tick,
    input  logic                   active,
    output logic                   unary
);

    logic [INPUT_WIDTH-1:0] value_q;
    logic [INPUT_WIDTH-1:0] value_eff;
    logic [INPUT_WIDTH:0]   pulse_end;
    logic                   f_bit;

    // A new value becomes effective in the same edge that latches it, so tick 0
    // of the new gamma cycle is already encoded with it.
    assign value_eff = load ? value_in : value_q;

    // One extra bit keeps value+width from wrapping; ticks never exceed the
    // cycle length, so the pulse is clipped at the cycle end for free.
    assign pulse_end = {1'b0, value_eff} + (INPUT_WIDTH+1)'(PULSE_WIDTH);

    always_comb begin
        f_bit = 1'b0;
        case (mode)
            B2U_FALLING: f_bit = (tick < value_eff);
            B2U_PULSE:   f_bit = (tick >= value_eff) && ({1'b0, tick} < pulse_end);
            default:     f_bit = (tick >= value_eff);
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!grst) begin
            value_q <= '0;
            unary   <= 1'b0;
        end else begin
            if (load) begin
                value_q <= value_in;
            end
            unary <= active & f_bit;
        end
    end

endmodule

// File: rtl/binary2unary_array.sv
// NUM_CH-channel binary-to-unary encoder with run-time mode; owns the gamma
// cycle FSM, tick counter and handshake shared by all lanes.
module binary2unary_array
    import b2u_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int INPUT_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                          aclk,
    input  logic                          grst,
    input  logic [1:0]                    mode,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_CH*INPUT_WIDTH-1:0] binary_input,
    output logic [NUM_CH-1:0]             unary_output,
    output logic                          gamma_start,
    output logic                          busy,
    output b2u_state_e                    state_dbg
);

    // Handshake: a vector and mode transfer on a rising edge where in_valid and
    // in_ready are both high; in_ready depends only on state and tick.
    localparam logic [INPUT_WIDTH-1:0] LAST_TICK = INPUT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    b2u_state_e             state_q, state_d;
    logic [INPUT_WIDTH-1:0] tick_q;
    b2u_mode_e              mode_q;
    b2u_mode_e              mode_eff;
    logic [INPUT_WIDTH-1:0] next_tick;
    logic                   at_last;
    logic                   hs;
    logic                   next_active;

    assign at_last   = (tick_q == LAST_TICK);
    assign in_ready  = (state_q == IDLE) || ((state_q == RUN) && at_last);
    assign hs        = in_valid & in_ready;
    assign busy      = (state_q == RUN);
    assign gamma_start = (state_q == RUN) && (tick_q == '0);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = RUN;
            RUN:     if (at_last && !hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!grst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            mode_q  <= B2U_RISING;
        end else begin
            state_q <= state_d;
            if (hs) begin
                tick_q <= '0;
                mode_q <= b2u_mode_e'(mode);
            end else if ((state_q == RUN) && !at_last) begin
                tick_q <= tick_q + INPUT_WIDTH'(1);
            end else begin
                tick_q <= '0;
            end
        end
    end

    // Lanes evaluate the tick that will be current after this edge.
    assign mode_eff    = hs ? b2u_mode_e'(mode) : mode_q;
    assign next_tick   = hs ? '0 : tick_q + INPUT_WIDTH'(1);
    assign next_active = hs | ((state_q == RUN) & !at_last);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        binary2unary_lane #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .PULSE_WIDTH (PULSE_WIDTH)
        ) u_lane (
            .aclk     (aclk),
            .grst     (grst),
            .load     (hs),
            .value_in (binary_input[c*INPUT_WIDTH +: INPUT_WIDTH]),
            .mode     (mode_eff),
            .tick     (next_tick),
            .active   (next_active),
            .unary    (unary_output[c])
        );
    end

endmodule

// File: tb/tb_binary2unary_array.sv
// Bench for binary2unary_array: directed scenarios plus random traffic, checked
// every cycle against a cycle-level behavioural model of the encoder.
module tb_binary2unary_array;
    import b2u_pkg::*;

    localparam int NUM_CH = 4;
    localparam int GCW    = 16;
    localparam int PW     = 8;
    localparam int IW     = 4;

    logic                 aclk = 1'b0;
    logic                 grst = 1'b0;
    logic [1:0]           mode = 2'b00;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [NUM_CH*IW-1:0] binary_input = '0;
    logic [NUM_CH-1:0]    unary_output;
    logic                 gamma_start;
    logic                 busy;
    b2u_state_e           state_dbg;

    binary2unary_array #(
        .NUM_CH            (NUM_CH),
        .GAMMA_CYCLE_WIDTH (GCW),
        .PULSE_WIDTH       (PW)
    ) dut (
        .aclk         (aclk),
        .grst         (grst),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .binary_input (binary_input),
        .unary_output (unary_output),
        .gamma_start  (gamma_start),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    always #5 aclk = ~aclk;

    int n_vec  = 0;
    int n_miss = 0;

    // Model: whether a gamma cycle runs, its tick, and the latched vector/mode.
    bit m_run  = 1'b0;
    int m_k    = 0;
    int m_mode = 0;
    int m_val[NUM_CH];
    int cur_val[NUM_CH];

    function automatic bit f_ref(int m, int v, int k);
        case (m)
            1:       return k < v;
            2:       return (k >= v) && (k < v + PW);
            default: return k >= v;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_miss++;
            $error("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic drive(input bit v, input int m, input int a, input int b, input int c, input int d);
        in_valid   = v;
        mode       = 2'(m);
        cur_val[0] = a;
        cur_val[1] = b;
        cur_val[2] = c;
        cur_val[3] = d;
        for (int i = 0; i < NUM_CH; i++) binary_input[i*IW +: IW] = IW'(cur_val[i]);
    endtask

    task automatic model_edge();
        bit ready;
        if (!grst) begin
            m_run  = 1'b0;
            m_k    = 0;
            m_mode = 0;
            for (int i = 0; i < NUM_CH; i++) m_val[i] = 0;
        end else begin
            ready = !m_run || (m_k == GCW - 1);
            if (in_valid && ready) begin
                m_run  = 1'b1;
                m_k    = 0;
                m_mode = int'(mode);
                for (int i = 0; i < NUM_CH; i++) m_val[i] = cur_val[i];
            end else if (m_run) begin
                if (m_k == GCW - 1) m_run = 1'b0;
                else                m_k++;
            end
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0] exp_u;
        exp_u = '0;
        if (m_run) for (int i = 0; i < NUM_CH; i++) exp_u[i] = f_ref(m_mode, m_val[i], m_k);
        check("unary_output", 32'(unary_output), 32'(exp_u));
        check("gamma_start", 32'(gamma_start), 32'(m_run && m_k == 0));
        check("busy", 32'(busy), 32'(m_run));
        check("in_ready", 32'(in_ready), 32'(!m_run || m_k == GCW - 1));
        check("state_dbg", 32'(state_dbg), m_run ? 32'(RUN) : 32'(IDLE));
    endtask

    task automatic step();
        @(posedge aclk);
        model_edge();
        @(negedge aclk);
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_val[i]   = 0;
            cur_val[i] = 0;
        end

        // Reset held for two cycles.
        drive(0, 0, 0, 0, 0, 0);
        grst = 1'b0;
        step();
        step();
        grst = 1'b1;
        step();

        // RISING {0,1,8,15}; back to IDLE on the 17th cycle.
        drive(1, 0, 0, 1, 8, 15);
        step();
        check("rise_k0", 32'(unary_output), 32'h1);
        drive(0, 3, 5, 5, 5, 5);
        repeat (16) step();
        check("rise_idle_busy", 32'(busy), 32'h0);

        // FALLING {0,1,8,15}.
        drive(1, 1, 0, 1, 8, 15);
        step();
        check("fall_k0", 32'(unary_output), 32'hE);
        drive(0, 0, 0, 0, 0, 0);
        repeat (16) step();

        // PULSE {0,8,12,15}, clipped at the cycle end.
        drive(1, 2, 0, 8, 12, 15);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (15) step();
        check("pulse_k15", 32'(unary_output), 32'hE);
        step();
        check("pulse_idle", 32'(unary_output), 32'h0);

        // Back-to-back with a mid-cycle mode toggle that must be ignored.
        drive(1, 0, 8, 8, 8, 8);
        step();
        drive(1, 2, 0, 0, 0, 0);
        repeat (6) step();
        drive(1, 1, 0, 0, 0, 0);
        repeat (4) step();
        drive(1, 2, 0, 0, 0, 0);
        repeat (5) step();
        check("b2b_k15_rise", 32'(unary_output), 32'hF);
        step();
        check("b2b_second_start", 32'(gamma_start), 32'h1);
        repeat (15) step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (18) step();

        // Reset at k=5 of a RISING {0,0,0,0} cycle.
        drive(1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (5) step();
        grst = 1'b0;
        step();
        check("rst_mid_ready", 32'(in_ready), 32'h1);
        grst = 1'b1;
        step();

        // Random traffic with occasional resets.
        repeat (400) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            grst = ($urandom_range(0, 49) != 0);
            step();
        end
        grst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (18) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
